// File: rtl/fpu_round_pack_if.sv
// Handshake/bus bundle for fpu_round_pack: unpacked operand in, packed IEEE single out.
// Both sides use valid/ready: a beat transfers on a rising edge where valid && ready;
// valid and its payload stay put until that edge, and ready never depends on valid.
interface fpu_round_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic [34:0] in_data;
    logic        in_exp_ovf;
    logic        in_exp_unf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_data, in_exp_ovf, in_exp_unf, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_exp_ovf, in_exp_unf, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpu_round_pack.sv
// Two-stage round-to-nearest-even and pack of an unpacked single-precision result.
// S1 registers the round decision and special-case class, S2 increments, packs and holds the output.
module fpu_round_pack (
    input  logic              clk,
    input  logic              rst_n,
    fpu_round_pack_if.slave   bus
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        incr;
        logic        inexact;
        logic        ovf;
        logic        unf;
    } s1_t;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic        in_g;
    logic        in_r;
    logic        in_s;

    assign in_sign = bus.in_data[34];
    assign in_exp  = bus.in_data[33:26];
    assign in_frac = bus.in_data[25:3];
    assign in_g    = bus.in_data[2];
    assign in_r    = bus.in_data[1];
    assign in_s    = bus.in_data[0];

    // Round decision and special-case classification; underflow beats overflow.
    s1_t dec;
    always_comb begin
        dec         = '0;
        dec.sign    = in_sign;
        dec.exp     = in_exp;
        dec.frac    = in_frac;
        dec.incr    = in_g && (in_r || in_s || in_frac[0]);
        dec.inexact = in_g || in_r || in_s;
        dec.unf     = bus.in_exp_unf || (in_exp == 8'h00);
        dec.ovf     = !dec.unf && (bus.in_exp_ovf || (in_exp == 8'hFF));
    end

    logic        s1_valid_q;
    logic        s1_valid_d;
    s1_t         s1_q;
    s1_t         s1_d;
    logic        s2_valid_q;
    logic        s2_valid_d;
    logic [31:0] s2_result_q;
    logic [31:0] s2_result_d;
    logic [2:0]  s2_flags_q;
    logic [2:0]  s2_flags_d;

    logic s2_can_load;
    logic in_ready;

    // Stall propagates from the consumer backwards; in_ready never looks at in_valid.
    assign s2_can_load = !s2_valid_q || bus.out_ready;
    assign in_ready    = !s1_valid_q || s2_can_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d = dec;
            end
        end
    end

    logic [24:0] mant_sum;
    logic        carry;
    logic [7:0]  exp_adj;
    logic [22:0] frac_adj;
    logic [31:0] pack_result;
    logic [2:0]  pack_flags;

    always_comb begin
        mant_sum = {1'b0, 1'b1, s1_q.frac} + {24'h0, s1_q.incr};
        carry    = mant_sum[24];
        exp_adj  = s1_q.exp + {7'h0, carry};
        frac_adj = carry ? 23'h0 : mant_sum[22:0];
        if (s1_q.unf) begin
            pack_result = {s1_q.sign, 31'h0};
            pack_flags  = 3'b011;
        end else if (s1_q.ovf || (exp_adj == 8'hFF)) begin
            pack_result = {s1_q.sign, 8'hFF, 23'h0};
            pack_flags  = 3'b101;
        end else begin
            pack_result = {s1_q.sign, exp_adj, frac_adj};
            pack_flags  = {2'b00, s1_q.inexact};
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (s2_can_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = pack_result;
                s2_flags_d  = pack_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 32'h0;
            s2_flags_q  <= 3'b000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_flags  = s2_flags_q;

endmodule

// File: tb/tb_fpu_round_pack.sv
// Bench for fpu_round_pack: directed corner cases, backpressure, reset, then random traffic
// scored against an arithmetic reference of round-to-nearest-even packing.
module tb_fpu_round_pack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_round_pack_if bus ();

    fpu_round_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [34:0] exp_q[$];

    logic [34:0] ops[4];
    int          idx;
    logic        acc;

    // Reference: value = 1.frac * 8 + grs, divide by 8 rounding half to even.
    function automatic logic [34:0] model(input logic [34:0] d, input logic ovf, input logic unf);
        logic        sign;
        int unsigned e;
        int unsigned full;
        int unsigned q;
        int unsigned rem;
        sign = d[34];
        e    = 32'(d[33:26]);
        full = (32'(d[25:3]) + 32'h0080_0000) * 8 + 32'(d[2:0]);
        q    = full / 8;
        rem  = full % 8;
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        if (q == 32'h0100_0000) begin
            q = q / 2;
            e = e + 1;
        end
        if (unf || d[33:26] == 8'h00) return {3'b011, sign, 31'h0};
        if (ovf || d[33:26] == 8'hFF || e >= 255) return {3'b101, sign, 8'hFF, 23'h0};
        return {2'b00, (rem != 0), sign, e[7:0], q[22:0]};
    endfunction

    function automatic logic [36:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        logic [2:0]  grs;
        logic        ovf;
        logic        unf;
        case ($urandom_range(0, 7))
            0:       e = 8'h00;
            1:       e = 8'h01;
            2:       e = 8'hFE;
            3:       e = 8'hFF;
            4:       e = 8'h7F;
            default: e = 8'($urandom_range(1, 254));
        endcase
        f   = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        grs = 3'($urandom);
        ovf = ($urandom_range(0, 15) == 0);
        unf = ($urandom_range(0, 15) == 0);
        return {ovf, unf, 1'($urandom), e, f, grs};
    endfunction

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Scoreboard: output must match the oldest outstanding operand every cycle it is valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL stale_out: got out_valid with %h expected no output", bus.out_result);
                end
                if (exp_q.size() != 0) begin
                    check("out_data", {bus.out_flags, bus.out_result}, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_data, bus.in_exp_ovf, bus.in_exp_unf));
        end
    end

    task automatic directed(input string tag, input logic [34:0] d, input logic ovf, input logic unf,
                            input logic [31:0] res, input logic [2:0] flg);
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_exp_ovf = ovf;
        bus.in_exp_unf = unf;
        @(negedge clk);
        check({tag, "_in_ready"}, 35'(bus.in_ready), 35'd1);
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.in_exp_ovf = 1'b0;
        bus.in_exp_unf = 1'b0;
        check({tag, "_lat1_valid"}, 35'(bus.out_valid), 35'd0);
        @(posedge clk);
        #1;
        check({tag, "_lat2_valid"}, 35'(bus.out_valid), 35'd1);
        check(tag, {bus.out_flags, bus.out_result}, {flg, res});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 35'(exp_q.size()), 35'd0);
    endtask

    initial begin
        logic [36:0] r;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_exp_ovf = 1'b0;
        bus.in_exp_unf = 1'b0;
        bus.out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 35'(bus.out_valid), 35'd0);
        check("rst_out", {bus.out_flags, bus.out_result}, 35'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 35'(bus.in_ready), 35'd1);
        @(posedge clk);
        #1;

        directed("one",        {1'b0, 8'h7F, 23'h0,      3'b000}, 1'b0, 1'b0, 32'h3F80_0000, 3'b000);
        directed("tie_carry",  {1'b0, 8'h7F, 23'h7FFFFF, 3'b100}, 1'b0, 1'b0, 32'h4000_0000, 3'b001);
        directed("tie_even",   {1'b1, 8'h7F, 23'h0,      3'b100}, 1'b0, 1'b0, 32'hBF80_0000, 3'b001);
        directed("tie_odd",    {1'b0, 8'h7F, 23'h1,      3'b100}, 1'b0, 1'b0, 32'h3F80_0002, 3'b001);
        directed("round_ovf",  {1'b0, 8'hFE, 23'h7FFFFF, 3'b110}, 1'b0, 1'b0, 32'h7F80_0000, 3'b101);
        directed("exp_unf",    {1'b1, 8'h80, 23'h123,    3'b000}, 1'b0, 1'b1, 32'h8000_0000, 3'b011);
        directed("exp_ovf",    {1'b1, 8'h10, 23'h0,      3'b000}, 1'b1, 1'b0, 32'hFF80_0000, 3'b101);
        directed("both_flags", {1'b0, 8'h10, 23'h55,     3'b001}, 1'b1, 1'b1, 32'h0000_0000, 3'b011);
        directed("exp_zero",   {1'b1, 8'h00, 23'h7FFFFF, 3'b111}, 1'b0, 1'b0, 32'h8000_0000, 3'b011);
        directed("exp_ff",     {1'b0, 8'hFF, 23'h0,      3'b000}, 1'b0, 1'b0, 32'h7F80_0000, 3'b101);

        // Full-rate burst: ready must stay high with the consumer always taking results.
        for (int c = 0; c < 8; c++) begin
            r = rand_op();
            bus.in_valid   = 1'b1;
            bus.in_data    = r[34:0];
            bus.in_exp_ovf = r[36];
            bus.in_exp_unf = r[35];
            @(negedge clk);
            check("burst_in_ready", 35'(bus.in_ready), 35'd1);
            @(posedge clk);
            #1;
        end
        bus.in_exp_ovf = 1'b0;
        bus.in_exp_unf = 1'b0;
        drain();

        // Backpressure: four operands offered while the consumer stalls for five cycles.
        for (int i = 0; i < 4; i++) begin
            r = rand_op();
            ops[i] = r[34:0];
        end
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ops[idx % 4];
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        check("bp_accepted", 35'(idx), 35'd2);
        check("bp_in_ready", 35'(bus.in_ready), 35'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ops[idx % 4];
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        check("bp_all_accepted", 35'(idx), 35'd4);
        drain();

        // Reset with both stages full: results in flight must vanish.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            r = rand_op();
            bus.in_valid = 1'b1;
            bus.in_data  = r[34:0];
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 35'(bus.out_valid), 35'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_valid", 35'(bus.out_valid), 35'd0);
        check("async_rst_out", {bus.out_flags, bus.out_result}, 35'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 35'(bus.in_ready), 35'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_no_out", 35'(bus.out_valid), 35'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure; payload held until accepted.
        acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.in_valid || acc) begin
                r = rand_op();
                bus.in_valid   = ($urandom_range(0, 3) != 0);
                bus.in_data    = r[34:0];
                bus.in_exp_ovf = r[36];
                bus.in_exp_unf = r[35];
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
